ft_recovery_ctrl: RTL and testbench
===================================

// Module: ft_recovery_ctrl
// PURPOSE
//  Recovery sequencer for the dual zeroriscy lockstep pair. Compares both cores' regfile write ports
//  and keeps a shadow regfile plus a checkpoint PC from matching writes.
//  On mismatch it drives both cores' debug ports: halt, rewrite GPRs x1..x31 and NPC, resume.
//  Sits beside the two cores in the SoC and owns all debug_* inputs of both cores.
// PARAMETERS
//  HALT_TIMEOUT  64      cycles to wait for both debug_halted before declaring fatal
//  FIRST_REG     1       first GPR rewritten (x0 never written)
// PORTS
//  clk_i              in   1   clock
//  rst_i              in   1   synchronous reset, active-high
//  we_a_i / we_b_i    in   1   regfile write enable, core 0 / core 1
//  waddr_a_i/waddr_b_i in  5   regfile write address, core 0 / core 1
//  wdata_a_i/wdata_b_i in  32  regfile write data, core 0 / core 1
//  pc_i               in   32  instr_addr of core 0
//  halted_a_i/halted_b_i in 1  debug_halted_o of core 0 / core 1
//  gnt_a_i / gnt_b_i  in   1   debug_gnt_o of core 0 / core 1
//  dbg_req_o          out  1   debug_req to both cores
//  dbg_we_o           out  1   debug_we to both cores
//  dbg_addr_o         out  15  debug_addr to both cores
//  dbg_wdata_o        out  32  debug_wdata to both cores
//  dbg_halt_o         out  1   debug_halt to both cores
//  dbg_resume_o       out  1   debug_resume to both cores (1-cycle pulse)
//  busy_o             out  1   recovery in progress
//  fatal_o            out  1   halt timeout; sticky until reset
//  rec_count_o        out  8   completed recoveries, saturates at 255
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, shadow regs 0, pc_ckpt 0.
//  Match = we_a&we_b & waddr_a==waddr_b & wdata_a==wdata_b.
//   On match with waddr!=0: shadow[waddr]<=wdata, pc_ckpt<=pc_i, same edge.
//  Mismatch = (we_a^we_b) | (we_a&we_b & (addr or data differ)); evaluated only in IDLE.
//   Mismatching write is never stored. In non-IDLE states all write inputs are ignored.
//  FSM (registered outputs, state changes on clk_i edge):
//   IDLE: mismatch -> HALT; busy_o=0.
//   HALT: dbg_halt_o=1 for one cycle; timer<=0 -> WAIT_HALTED; busy_o=1 from here until IDLE.
//   WAIT_HALTED: dbg_halt_o held 1; halted_a&halted_b -> WR_GPR, idx<=FIRST_REG.
//    timer==HALT_TIMEOUT-1 -> FAIL.
//   WR_GPR: dbg_req_o=1, dbg_we_o=1, dbg_addr_o=15'h400+{idx,2'b00}, dbg_wdata_o=shadow[idx].
//    Per-core sticky gnt flags; beat done when both flags set (same or different cycles).
//    On done: flags clear, req drops for 1 cycle; idx==31 -> WR_PC else idx+1.
//   WR_PC: same handshake, addr=15'h2000, wdata=pc_ckpt+32'd4 (mod 2^32) -> RESUME.
//   RESUME: dbg_resume_o=1 one cycle, dbg_halt_o=0, rec_count_o+=1 (sat 255) -> IDLE.
//   FAIL: fatal_o=1, dbg_halt_o=1 held, no requests; exits only on rst_i.
//  dbg_addr_o/dbg_wdata_o stay stable while dbg_req_o=1; both 0 when req=0.
//  Mismatch arriving on the RESUME cycle is ignored; next one in IDLE starts a new recovery.
//  rst_i mid-recovery: immediate IDLE, req/halt drop; shadow contents cleared.
// TESTING
//  Ten matching writes x5=0xA5A5_0005 at pc 0x100 -> shadow[5]=0xA5A5_0005, pc_ckpt=0x100, busy_o=0.
//  wdata_b differs on waddr 7 -> halt 1 cycle later; both halted; 31 GPR writes; then 0x2000<=0x104; resume pulse.
//  gnt_a 3 cycles before gnt_b each beat -> addr/data held; each beat advances once; 32 beats total.
//  halted_b never asserts -> fatal_o=1 after 64 cycles of WAIT_HALTED; req stays 0; halt stays 1.
//  rst_i asserted during WR_GPR idx=12 -> next cycle all outputs 0, state IDLE.
//  256 recoveries -> rec_count_o saturates at 255; we_a only, waddr 0 -> treated as mismatch.

Source files
------------

// File: rtl/ft_recovery_ctrl.sv
// Lockstep recovery sequencer: shadows matching regfile writes of two cores and, on divergence,
// halts both cores, restores x1..x31 and the NPC through their debug ports, then resumes them.
module ft_recovery_ctrl #(
  parameter int HALT_TIMEOUT = 64,
  parameter int FIRST_REG    = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_a_i,
  input  logic        we_b_i,
  input  logic [4:0]  waddr_a_i,
  input  logic [4:0]  waddr_b_i,
  input  logic [31:0] wdata_a_i,
  input  logic [31:0] wdata_b_i,
  input  logic [31:0] pc_i,
  input  logic        halted_a_i,
  input  logic        halted_b_i,
  input  logic        gnt_a_i,
  input  logic        gnt_b_i,
  output logic        dbg_req_o,
  output logic        dbg_we_o,
  output logic [14:0] dbg_addr_o,
  output logic [31:0] dbg_wdata_o,
  output logic        dbg_halt_o,
  output logic        dbg_resume_o,
  output logic        busy_o,
  output logic        fatal_o,
  output logic [7:0]  rec_count_o
);

  localparam int TW = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(HALT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HALT   = 3'd1,
    S_WAIT   = 3'd2,
    S_WR_GPR = 3'd3,
    S_WR_PC  = 3'd4,
    S_RESUME = 3'd5,
    S_FAIL   = 3'd6
  } state_t;

  state_t        state_r, state_s;
  logic [TW-1:0] timer_r, timer_s;
  logic [4:0]    idx_r, idx_s;
  logic          gap_r, gap_s;
  logic          flag_a_r, flag_a_s, flag_b_r, flag_b_s;
  logic [7:0]    rec_s;
  logic [31:0]   shadow_r [0:31];
  logic [31:0]   pc_ckpt_r;

  logic          req_s, halt_s;
  logic [14:0]   addr_s;
  logic [31:0]   wdata_s;

  logic match_s, mismatch_s, shadow_we_s, done_s;

  assign match_s     = we_a_i & we_b_i & (waddr_a_i == waddr_b_i) & (wdata_a_i == wdata_b_i);
  assign mismatch_s  = (we_a_i ^ we_b_i) |
                       (we_a_i & we_b_i & ((waddr_a_i != waddr_b_i) | (wdata_a_i != wdata_b_i)));
  assign shadow_we_s = (state_r == S_IDLE) & match_s & (waddr_a_i != 5'd0);
  // A beat completes once each core has granted, in the same or in different cycles.
  assign done_s      = dbg_req_o & (flag_a_r | gnt_a_i) & (flag_b_r | gnt_b_i);

  // Next-state logic plus the next value of every registered output.
  always_comb begin
    state_s  = state_r;
    timer_s  = timer_r;
    idx_s    = idx_r;
    gap_s    = 1'b0;
    flag_a_s = flag_a_r;
    flag_b_s = flag_b_r;
    rec_s    = rec_count_o;
    case (state_r)
      S_IDLE: begin
        if (mismatch_s) state_s = S_HALT;
        else            state_s = S_IDLE;
      end
      S_HALT: begin
        timer_s = '0;
        state_s = S_WAIT;
      end
      S_WAIT: begin
        if (halted_a_i & halted_b_i) begin
          state_s  = S_WR_GPR;
          idx_s    = 5'(FIRST_REG);
          flag_a_s = 1'b0;
          flag_b_s = 1'b0;
        end else if (timer_r == TIMER_LAST) begin
          state_s = S_FAIL;
        end else begin
          timer_s = timer_r + TW'(1);
        end
      end
      S_WR_GPR, S_WR_PC: begin
        if (done_s) begin
          flag_a_s = 1'b0;
          flag_b_s = 1'b0;
          gap_s    = 1'b1;
          if (state_r == S_WR_PC) begin
            state_s = S_RESUME;
            if (rec_count_o != 8'hFF) rec_s = rec_count_o + 8'd1;
            else                      rec_s = rec_count_o;
          end else if (idx_r == 5'd31) begin
            state_s = S_WR_PC;
          end else begin
            idx_s = idx_r + 5'd1;
          end
        end else begin
          flag_a_s = flag_a_r | (dbg_req_o & gnt_a_i);
          flag_b_s = flag_b_r | (dbg_req_o & gnt_b_i);
        end
      end
      S_RESUME: state_s = S_IDLE;
      S_FAIL:   state_s = S_FAIL;
      default:  state_s = S_IDLE;
    endcase

    req_s  = ((state_s == S_WR_GPR) | (state_s == S_WR_PC)) & ~gap_s;
    halt_s = state_s inside {S_HALT, S_WAIT, S_WR_GPR, S_WR_PC, S_FAIL};
    if (req_s) begin
      if (state_s == S_WR_PC) begin
        addr_s  = 15'h2000;
        wdata_s = pc_ckpt_r + 32'd4;
      end else begin
        addr_s  = 15'h0400 + {8'd0, idx_s, 2'b00};
        wdata_s = shadow_r[idx_s];
      end
    end else begin
      addr_s  = 15'd0;
      wdata_s = 32'd0;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= S_IDLE;
      timer_r      <= '0;
      idx_r        <= 5'd0;
      gap_r        <= 1'b0;
      flag_a_r     <= 1'b0;
      flag_b_r     <= 1'b0;
      dbg_req_o    <= 1'b0;
      dbg_we_o     <= 1'b0;
      dbg_addr_o   <= 15'd0;
      dbg_wdata_o  <= 32'd0;
      dbg_halt_o   <= 1'b0;
      dbg_resume_o <= 1'b0;
      busy_o       <= 1'b0;
      fatal_o      <= 1'b0;
      rec_count_o  <= 8'd0;
    end else begin
      state_r      <= state_s;
      timer_r      <= timer_s;
      idx_r        <= idx_s;
      gap_r        <= gap_s;
      flag_a_r     <= flag_a_s;
      flag_b_r     <= flag_b_s;
      dbg_req_o    <= req_s;
      dbg_we_o     <= req_s;
      dbg_addr_o   <= addr_s;
      dbg_wdata_o  <= wdata_s;
      dbg_halt_o   <= halt_s;
      dbg_resume_o <= (state_s == S_RESUME);
      busy_o       <= (state_s != S_IDLE);
      fatal_o      <= (state_s == S_FAIL);
      rec_count_o  <= rec_s;
    end
  end

  // Shadow regfile and checkpoint PC, fed only by agreeing writes while idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) shadow_r[i] <= 32'd0;
      pc_ckpt_r <= 32'd0;
    end else if (shadow_we_s) begin
      shadow_r[waddr_a_i] <= wdata_a_i;
      pc_ckpt_r           <= pc_i;
    end else begin
      pc_ckpt_r <= pc_ckpt_r;
    end
  end

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Self-checking bench for ft_recovery_ctrl: a model shadow regfile feeds a scoreboard of
// expected debug-port writes that is consumed as the DUT issues each beat.
module tb_ft_recovery_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_a, we_b;
  logic [4:0]  waddr_a, waddr_b;
  logic [31:0] wdata_a, wdata_b, pc;
  logic        halted_a, halted_b, gnt_a, gnt_b;
  logic        dbg_req, dbg_we, dbg_halt, dbg_resume, busy, fatal;
  logic [14:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic [7:0]  rec_count;

  typedef struct packed {
    logic [14:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] shadow_m [0:31];
  logic [31:0] pc_m;
  int          rec_m;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  ft_recovery_ctrl #(.HALT_TIMEOUT(64), .FIRST_REG(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .we_a_i(we_a), .we_b_i(we_b),
    .waddr_a_i(waddr_a), .waddr_b_i(waddr_b),
    .wdata_a_i(wdata_a), .wdata_b_i(wdata_b),
    .pc_i(pc),
    .halted_a_i(halted_a), .halted_b_i(halted_b),
    .gnt_a_i(gnt_a), .gnt_b_i(gnt_b),
    .dbg_req_o(dbg_req), .dbg_we_o(dbg_we), .dbg_addr_o(dbg_addr), .dbg_wdata_o(dbg_wdata),
    .dbg_halt_o(dbg_halt), .dbg_resume_o(dbg_resume),
    .busy_o(busy), .fatal_o(fatal), .rec_count_o(rec_count)
  );

  task automatic model_clear();
    for (int i = 0; i < 32; i++) shadow_m[i] = 32'd0;
    pc_m  = 32'd0;
    rec_m = 0;
    exp_q.delete();
  endtask

  task automatic write_match(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    we_a = 1'b1; we_b = 1'b1; waddr_a = a; waddr_b = a; wdata_a = d; wdata_b = d; pc = p;
    @(negedge clk);
    we_a = 1'b0; we_b = 1'b0;
    if (a != 5'd0) begin
      shadow_m[a] = d;
      pc_m = p;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    checks++;
    if ({dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt, dbg_resume, busy, fatal, rec_count} !== 63'd0) begin
      failures++;
      $display("FAIL reset_outputs req=%b we=%b addr=%h wdata=%h halt=%b resume=%b busy=%b fatal=%b rec=%0d required all 0",
               dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt, dbg_resume, busy, fatal, rec_count);
    end
  endtask

  task automatic test_shadow_writes();
    for (int r = 1; r < 32; r++) write_match(5'(r), $urandom, 32'h0000_0040 + 32'(r * 4));
    for (int k = 0; k < 10; k++) write_match(5'd5, 32'hA5A5_0005, 32'h0000_0100);
    write_match(5'd0, 32'hDEAD_BEEF, 32'h0000_0DEC);
    checks++;
    if ({busy, dbg_halt, dbg_req} !== 3'b000) begin
      failures++;
      $display("FAIL shadow_idle busy=%b halt=%b req=%b required 0 0 0", busy, dbg_halt, dbg_req);
    end
  endtask

  // kind 0: data mismatch on x7; kind 1: write enable on core 0 only, waddr 0
  task automatic start_recovery(input int kind, input bit both_halt);
    if (both_halt) begin
      for (int i = 1; i < 32; i++) exp_q.push_back({15'h0400 + 15'(i * 4), shadow_m[i]});
      exp_q.push_back({15'h2000, pc_m + 32'd4});
    end
    if (kind == 0) begin
      we_a = 1'b1; we_b = 1'b1; waddr_a = 5'd7; waddr_b = 5'd7;
      wdata_a = 32'h7777_0000; wdata_b = 32'h7777_0001;
    end else begin
      we_a = 1'b1; we_b = 1'b0; waddr_a = 5'd0; waddr_b = 5'd0; wdata_a = 32'h0; wdata_b = 32'h0;
    end
    @(negedge clk);
    we_a = 1'b0; we_b = 1'b0;
    checks++;
    if ({dbg_halt, busy, dbg_req} !== 3'b110) begin
      failures++;
      $display("FAIL halt_start halt=%b busy=%b req=%b required 1 1 0", dbg_halt, busy, dbg_req);
    end
    halted_a = 1'b1; halted_b = both_halt;
    @(negedge clk);
    checks++;
    if ({dbg_halt, busy, dbg_req, dbg_resume} !== 4'b1100) begin
      failures++;
      $display("FAIL halt_hold halt=%b busy=%b req=%b resume=%b required 1 1 0 0", dbg_halt, busy, dbg_req, dbg_resume);
    end
  endtask

  task automatic serve_beats(input int n, input int da, input int db);
    int    w;
    int    mx;
    beat_t e;
    mx = (da > db) ? da : db;
    for (int b = 0; b < n; b++) begin
      w = 0;
      while (dbg_req !== 1'b1 && w < 20) begin
        @(negedge clk);
        w++;
      end
      checks++;
      if (dbg_req !== 1'b1 || exp_q.size() == 0) begin
        failures++;
        $display("FAIL beat_req_timeout beat=%0d req=%b queued=%0d required req 1", b, dbg_req, exp_q.size());
        return;
      end
      e = exp_q.pop_front();
      checks++;
      if ({dbg_we, dbg_addr, dbg_wdata} !== {1'b1, e.addr, e.data}) begin
        failures++;
        $display("FAIL beat_value beat=%0d we=%b addr=%h data=%h required 1 %h %h", b, dbg_we, dbg_addr, dbg_wdata, e.addr, e.data);
      end
      for (int c = 0; c <= mx; c++) begin
        if (c > 0) begin
          checks++;
          if ({dbg_req, dbg_addr, dbg_wdata} !== {1'b1, e.addr, e.data}) begin
            failures++;
            $display("FAIL beat_hold beat=%0d req=%b addr=%h data=%h required 1 %h %h", b, dbg_req, dbg_addr, dbg_wdata, e.addr, e.data);
          end
        end
        gnt_a = (c == da);
        gnt_b = (c == db);
        @(negedge clk);
      end
      gnt_a = 1'b0; gnt_b = 1'b0;
      checks++;
      if ({dbg_req, dbg_addr, dbg_wdata} !== 48'd0) begin
        failures++;
        $display("FAIL beat_gap beat=%0d req=%b addr=%h data=%h required all 0", b, dbg_req, dbg_addr, dbg_wdata);
      end
    end
  endtask

  task automatic finish_recovery(input bit resume_mm);
    rec_m = (rec_m < 255) ? rec_m + 1 : 255;
    checks++;
    if ({dbg_resume, dbg_halt, dbg_req, busy} !== 4'b1001) begin
      failures++;
      $display("FAIL resume_pulse resume=%b halt=%b req=%b busy=%b required 1 0 0 1", dbg_resume, dbg_halt, dbg_req, busy);
    end
    checks++;
    if (rec_count !== 8'(rec_m)) begin
      failures++;
      $display("FAIL rec_count got=%0d required=%0d", rec_count, rec_m);
    end
    halted_a = 1'b0; halted_b = 1'b0;
    if (resume_mm) begin
      we_a = 1'b1; we_b = 1'b0; waddr_a = 5'd3;
    end
    @(negedge clk);
    we_a = 1'b0; we_b = 1'b0;
    checks++;
    if ({dbg_resume, dbg_halt, busy} !== 3'b000) begin
      failures++;
      $display("FAIL resume_end resume=%b halt=%b busy=%b required 0 0 0", dbg_resume, dbg_halt, busy);
    end
    @(negedge clk);
    checks++;
    if ({dbg_halt, busy} !== 2'b00) begin
      failures++;
      $display("FAIL resume_mismatch_ignored halt=%b busy=%b required 0 0", dbg_halt, busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover queued=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_recovery();
    start_recovery(0, 1'b1);
    serve_beats(32, 0, 0);
    finish_recovery(1'b1);
  endtask

  task automatic test_gnt_skew();
    start_recovery(0, 1'b1);
    serve_beats(16, 0, 3);
    serve_beats(16, 2, 0);
    finish_recovery(1'b0);
  endtask

  task automatic test_reset_mid();
    int w;
    start_recovery(0, 1'b1);
    serve_beats(11, 1, 1);
    w = 0;
    while (dbg_req !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if ({dbg_req, dbg_addr, dbg_wdata} !== {1'b1, 15'h0430, shadow_m[12]}) begin
      failures++;
      $display("FAIL mid_idx12 req=%b addr=%h data=%h required 1 0430 %h", dbg_req, dbg_addr, dbg_wdata, shadow_m[12]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    halted_a = 1'b0; halted_b = 1'b0;
    model_clear();
    checks++;
    if ({dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt, dbg_resume, busy, fatal, rec_count} !== 63'd0) begin
      failures++;
      $display("FAIL mid_reset req=%b halt=%b busy=%b addr=%h wdata=%h rec=%0d required all 0",
               dbg_req, dbg_halt, busy, dbg_addr, dbg_wdata, rec_count);
    end
    @(negedge clk);
    checks++;
    if ({dbg_halt, busy, dbg_req} !== 3'b000) begin
      failures++;
      $display("FAIL mid_reset_idle halt=%b busy=%b req=%b required 0 0 0", dbg_halt, busy, dbg_req);
    end
  endtask

  task automatic test_saturation();
    write_match(5'd1, 32'h0000_0001, 32'hFFFF_FFFC);
    for (int k = 0; k < 256; k++) begin
      start_recovery(1, 1'b1);
      serve_beats(32, 0, 0);
      finish_recovery(1'b0);
    end
    checks++;
    if (rec_count !== 8'd255) begin
      failures++;
      $display("FAIL rec_saturate got=%0d required=255", rec_count);
    end
  endtask

  task automatic test_halt_timeout();
    start_recovery(0, 1'b0);
    repeat (63) @(negedge clk);
    checks++;
    if ({fatal, dbg_halt, dbg_req} !== 3'b010) begin
      failures++;
      $display("FAIL timeout_early fatal=%b halt=%b req=%b required 0 1 0", fatal, dbg_halt, dbg_req);
    end
    @(negedge clk);
    checks++;
    if ({fatal, dbg_halt, dbg_req, busy} !== 4'b1101) begin
      failures++;
      $display("FAIL timeout_fatal fatal=%b halt=%b req=%b busy=%b required 1 1 0 1", fatal, dbg_halt, dbg_req, busy);
    end
    halted_b = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({fatal, dbg_halt, dbg_req, dbg_resume} !== 4'b1100) begin
      failures++;
      $display("FAIL fatal_sticky fatal=%b halt=%b req=%b resume=%b required 1 1 0 0", fatal, dbg_halt, dbg_req, dbg_resume);
    end
    halted_a = 1'b0; halted_b = 1'b0;
    test_reset();
  endtask

  initial begin
    rst = 1'b1; we_a = 1'b0; we_b = 1'b0; waddr_a = 5'd0; waddr_b = 5'd0;
    wdata_a = 32'd0; wdata_b = 32'd0; pc = 32'd0;
    halted_a = 1'b0; halted_b = 1'b0; gnt_a = 1'b0; gnt_b = 1'b0;
    @(negedge clk);
    test_reset();
    test_shadow_writes();
    test_recovery();
    test_gnt_skew();
    test_reset_mid();
    test_saturation();
    test_halt_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
